// File: rtl/xbar_pkg.sv
// Shared crossbar types: default widths, the {dest,data} beat and the
// occupancy-derived ingress state encoding.
package xbar_pkg;

  localparam int XBAR_M      = 4;
  localparam int XBAR_DATA_W = 32;
  localparam int XBAR_DEST_W = $clog2(XBAR_M);

  typedef struct packed {
    logic [XBAR_DEST_W-1:0] dest;
    logic [XBAR_DATA_W-1:0] data;
  } xbar_beat_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PEND  = 2'd1,
    ST_FULL  = 2'd2
  } ingress_state_e;

endpackage

// File: rtl/xbar_sync_fifo.sv
// Synchronous FIFO holding crossbar beats. The head entry is shown
// combinationally from rd_ptr. Push and pop arrive already qualified by the
// caller, so this block never has to guard against over/underflow itself.
module xbar_sync_fifo
  import xbar_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = xbar_beat_t,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  T                 i_wdata,
  output T                 o_head,
  output logic [LVL_W-1:0] o_level
);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  // Storage, pointers and occupancy. DEPTH is a power of 2, so the pointers
  // wrap on their own when they overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_mem    <= '{default: '0};
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/crossbar_ingress_port.sv
// Ingress queue for one crossbar input. It presents the FIFO head as
// req/dest/data, pops the head on grant, and counts ungranted cycles so that
// a head starved by the arbiter shows up as stall.
module crossbar_ingress_port
  import xbar_pkg::*;
#(
  parameter int  M           = XBAR_M,
  parameter int  DATA_W      = XBAR_DATA_W,
  parameter int  DEPTH       = 4,
  parameter int  STALL_LIMIT = 15,
  localparam int DEST_W      = $clog2(M),
  localparam int LVL_W       = $clog2(DEPTH + 1),
  localparam int WCNT_W      = $clog2(STALL_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_data,
  output logic              xb_req,
  output logic [DEST_W-1:0] xb_dest,
  output logic [DATA_W-1:0] xb_data,
  input  logic              xb_grant,
  output logic [LVL_W-1:0]  level,
  output logic              stall
);

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t           w_wbeat;
  beat_t           w_head;
  logic [LVL_W-1:0] w_level;
  ingress_state_e   w_state;
  logic             w_push;
  logic             w_pop;
  logic [WCNT_W-1:0] r_wait_cnt;

  // Occupancy class. EMPTY and FULL drive the handshake. Pushes are refused
  // while FULL even if a pop happens on the same edge.
  always_comb begin
    w_state = ST_EMPTY;
    if (w_level == LVL_W'(DEPTH)) w_state = ST_FULL;
    else if (w_level != '0)       w_state = ST_PEND;
  end

  // rst_n gating keeps req/ready low for the whole reset window, not only
  // after the first reset edge.
  assign in_ready = rst_n && (w_state != ST_FULL);
  assign xb_req   = rst_n && (w_state != ST_EMPTY);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = xb_req && xb_grant;

  assign w_wbeat.dest = in_dest;
  assign w_wbeat.data = in_data;
  assign xb_dest      = w_head.dest;
  assign xb_data      = w_head.data;

  xbar_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (beat_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wbeat),
    .o_head  (w_head),
    .o_level (w_level)
  );

  assign level = w_level;

  // Cycles the current head has waited without a grant. The counter
  // saturates at the limit and restarts when the head is popped or the
  // queue empties.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_wait_cnt <= '0;
    else if (w_pop || w_state == ST_EMPTY)
      r_wait_cnt <= '0;
    else if (xb_req && !xb_grant && r_wait_cnt != WCNT_W'(STALL_LIMIT))
      r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
  end

  assign stall = rst_n && (r_wait_cnt == WCNT_W'(STALL_LIMIT));

endmodule

// File: tb/tb_crossbar_ingress_port.sv
// Directed bench for crossbar_ingress_port. Inputs change 1ns after posedge
// and outputs are sampled there; every expected value is hand-computed.
module tb_crossbar_ingress_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_dest;
  logic [31:0] in_data;
  logic        xb_req;
  logic [1:0]  xb_dest;
  logic [31:0] xb_data;
  logic        xb_grant;
  logic [2:0]  level;
  logic        stall;

  int checks   = 0;
  int failures = 0;

  crossbar_ingress_port #(.M(4), .DATA_W(32), .DEPTH(4), .STALL_LIMIT(15)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_dest  (in_dest),
    .in_data  (in_data),
    .xb_req   (xb_req),
    .xb_dest  (xb_dest),
    .xb_data  (xb_data),
    .xb_grant (xb_grant),
    .level    (level),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] d, input logic [31:0] v);
    in_valid = 1'b1;
    in_dest  = d;
    in_data  = v;
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] fill_data [4];

  initial begin
    fill_data[0] = 32'hA1A1A1A1;
    fill_data[1] = 32'hB2B2B2B2;
    fill_data[2] = 32'hC3C3C3C3;
    fill_data[3] = 32'hD4D4D4D4;

    // 1: reset held 3 cycles while upstream keeps offering a beat
    rst_n = 1'b0; in_valid = 1'b1; in_dest = 2'd1; in_data = 32'h5; xb_grant = 1'b0;
    repeat (3) step();
    chk("rst_req", xb_req, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_level", level, 0);
    chk("rst_stall", stall, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_level", level, 0);
    chk("post_rst_ready", in_ready, 1);

    // 2: fill to full with no grant, then drain and check the order
    for (int i = 0; i < 4; i++) begin
      push(2'(i), fill_data[i]);
      if (i == 0) begin
        chk("lat_req", xb_req, 1);
        chk("lat_data", xb_data, 32'hA1A1A1A1);
      end
    end
    chk("full_level", level, 4);
    chk("full_ready", in_ready, 0);
    step();
    chk("hold_data", xb_data, 32'hA1A1A1A1);
    chk("hold_dest", xb_dest, 0);
    xb_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_dest%0d", i), xb_dest, 64'(i));
      chk($sformatf("drain_data%0d", i), xb_data, fill_data[i]);
      step();
    end
    xb_grant = 1'b0;
    chk("drain_level", level, 0);
    chk("drain_req", xb_req, 0);

    // 3: a single ungranted beat reaches stall after 15 waiting edges
    push(2'd2, 32'hDEADBEEF);
    repeat (14) step();
    chk("stall_pre", stall, 0);
    step();
    chk("stall_set", stall, 1);
    repeat (3) step();
    chk("stall_sat", stall, 1);
    chk("stall_dest", xb_dest, 2);
    chk("stall_data", xb_data, 32'hDEADBEEF);
    xb_grant = 1'b1;
    step();
    xb_grant = 1'b0;
    chk("stall_clr", stall, 0);
    chk("stall_req", xb_req, 0);
    chk("stall_level", level, 0);

    // 4: full queue, offered push plus grant -> only the pop happens
    for (int i = 0; i < 4; i++) push(2'd0, 32'(i + 1));
    chk("f4_level", level, 4);
    in_valid = 1'b1; in_dest = 2'd3; in_data = 32'h99; xb_grant = 1'b1;
    step();
    in_valid = 1'b0; xb_grant = 1'b0;
    chk("f4_pop_level", level, 3);
    chk("f4_ready", in_ready, 1);
    chk("f4_head", xb_data, 32'h2);
    xb_grant = 1'b1;
    repeat (3) step();
    xb_grant = 1'b0;
    chk("f4_drained", level, 0);

    // 5: a grant while empty is ignored; then sustained push+pop at level 2
    xb_grant = 1'b1;
    step();
    chk("spur_level", level, 0);
    chk("spur_req", xb_req, 0);
    xb_grant = 1'b0;
    push(2'd1, 32'h50);
    push(2'd1, 32'h51);
    chk("pp_level0", level, 2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pp_head%0d", i), xb_data, 32'h50 + 32'(i));
      in_valid = 1'b1; in_dest = 2'd1; in_data = 32'h52 + 32'(i); xb_grant = 1'b1;
      step();
      chk($sformatf("pp_level%0d", i + 1), level, 2);
    end
    in_valid = 1'b0;
    chk("pp_wrap0", xb_data, 32'h58);
    step();
    chk("pp_wrap1", xb_data, 32'h59);
    step();
    xb_grant = 1'b0;
    chk("pp_empty", level, 0);

    // 6: reset while three beats are queued and the counter is running
    for (int i = 0; i < 3; i++) push(2'd3, 32'h61 + 32'(i));
    repeat (5) step();
    chk("mr_level_pre", level, 3);
    rst_n = 1'b0;
    step();
    chk("mr_level", level, 0);
    chk("mr_req", xb_req, 0);
    chk("mr_stall", stall, 0);
    chk("mr_ready", in_ready, 0);
    rst_n = 1'b1;
    step();
    chk("mr_idle_req", xb_req, 0);
    push(2'd1, 32'hCAFEBABE);
    chk("mr_new_req", xb_req, 1);
    chk("mr_new_data", xb_data, 32'hCAFEBABE);
    chk("mr_new_dest", xb_dest, 1);
    chk("mr_new_level", level, 1);
    repeat (14) step();
    chk("mr_wait_restart", stall, 0);
    step();
    chk("mr_wait_stall", stall, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
